// File: rtl/proc_bus_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : proc_bus_mux_if
// Description : Select/bus handshake bundle for proc_bus_mux.
// Revision    : 1.0 - initial release
// ============================================================================
interface proc_bus_mux_if #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int ERRW  = 4
);
    localparam int IDXW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [NREG*WIDTH-1:0] R_bus;
    logic [WIDTH-1:0]      DIN;
    logic [WIDTH-1:0]      G;
    logic [NREG-1:0]       selectR;
    logic                  selectG;
    logic                  selectDin;
    logic                  sel_valid;
    logic                  sel_ready;
    logic                  bus_ready;
    logic [WIDTH-1:0]      MUXOut;
    logic                  bus_valid;
    logic [1:0]            src_code;
    logic [IDXW-1:0]       reg_idx;
    logic                  err_clear;
    logic                  sel_err;
    logic [ERRW-1:0]       err_count;

    modport master (
        output R_bus, DIN, G, selectR, selectG, selectDin, sel_valid,
               bus_ready, err_clear,
        input  sel_ready, MUXOut, bus_valid, src_code, reg_idx, sel_err,
               err_count
    );

    modport slave (
        input  R_bus, DIN, G, selectR, selectG, selectDin, sel_valid,
               bus_ready, err_clear,
        output sel_ready, MUXOut, bus_valid, src_code, reg_idx, sel_err,
               err_count
    );
endinterface
`default_nettype wire

// File: rtl/proc_bus_mux.sv
`default_nettype none
// ============================================================================
// Module      : proc_bus_mux
// Description : Registered processor bus mux with valid/ready output and
//               illegal-select error tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_bus_mux #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int ERRW  = 4
) (
    input  wire logic       Clock,
    input  wire logic       Reset,
    proc_bus_mux_if.slave   bus
);
    localparam int IDXW = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [1:0] C_SRC_REG  = 2'd0;
    localparam logic [1:0] C_SRC_DIN  = 2'd1;
    localparam logic [1:0] C_SRC_G    = 2'd2;
    localparam logic [1:0] C_SRC_NONE = 2'd3;
    localparam logic [ERRW-1:0] C_ERR_MAX = {ERRW{1'b1}};

    logic [WIDTH-1:0] muxout_q, muxout_d;
    logic             bus_valid_q, bus_valid_d;
    logic [1:0]       src_code_q, src_code_d;
    logic [IDXW-1:0]  reg_idx_q, reg_idx_d;
    logic             sel_err_q, sel_err_d;
    logic [ERRW-1:0]  err_count_q, err_count_d;

    logic [4:0]       hot_cnt;
    logic [IDXW-1:0]  hot_idx;
    logic [WIDTH-1:0] hot_data;
    logic             sel_ready;
    logic             accept;
    logic             legal;

    // Decode the register one-hot; the index/data are only used when exactly one bit is set.
    always_comb begin
        hot_cnt  = '0;
        hot_idx  = '0;
        hot_data = '0;
        for (int k = 0; k < NREG; k++) begin
            if (bus.selectR[k]) begin
                hot_cnt  = hot_cnt + 5'd1;
                hot_idx  = IDXW'(k);
                hot_data = bus.R_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_ready = !bus_valid_q || bus.bus_ready;
    assign accept    = bus.sel_valid && sel_ready;
    assign legal     = bus.selectG || bus.selectDin || (hot_cnt == 5'd1);

    always_comb begin
        muxout_d    = muxout_q;
        bus_valid_d = bus_valid_q;
        src_code_d  = src_code_q;
        reg_idx_d   = reg_idx_q;
        sel_err_d   = sel_err_q;
        err_count_d = err_count_q;

        if (bus_valid_q && bus.bus_ready) begin
            bus_valid_d = 1'b0;
        end

        if (accept && legal) begin
            bus_valid_d = 1'b1;
            if (bus.selectG) begin
                muxout_d   = bus.G;
                src_code_d = C_SRC_G;
                reg_idx_d  = '0;
            end else if (bus.selectDin) begin
                muxout_d   = bus.DIN;
                src_code_d = C_SRC_DIN;
                reg_idx_d  = '0;
            end else begin
                muxout_d   = hot_data;
                src_code_d = C_SRC_REG;
                reg_idx_d  = hot_idx;
            end
        end

        // A clear in the same cycle as an illegal accept leaves exactly that one error recorded.
        if (accept && !legal) begin
            sel_err_d = 1'b1;
            if (bus.err_clear) begin
                err_count_d = ERRW'(1);
            end else if (err_count_q != C_ERR_MAX) begin
                err_count_d = err_count_q + ERRW'(1);
            end
        end else if (bus.err_clear) begin
            sel_err_d   = 1'b0;
            err_count_d = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            muxout_q    <= '0;
            bus_valid_q <= 1'b0;
            src_code_q  <= C_SRC_NONE;
            reg_idx_q   <= '0;
            sel_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            muxout_q    <= muxout_d;
            bus_valid_q <= bus_valid_d;
            src_code_q  <= src_code_d;
            reg_idx_q   <= reg_idx_d;
            sel_err_q   <= sel_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.sel_ready = sel_ready;
    assign bus.MUXOut    = muxout_q;
    assign bus.bus_valid = bus_valid_q;
    assign bus.src_code  = src_code_q;
    assign bus.reg_idx   = reg_idx_q;
    assign bus.sel_err   = sel_err_q;
    assign bus.err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_proc_bus_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_bus_mux
// Description : Scoreboard bench for proc_bus_mux (directed + random traffic).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_bus_mux;
    localparam int WIDTH = 16;
    localparam int NREG  = 8;
    localparam int ERRW  = 4;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [1:0]       src;
        logic [2:0]       idx;
    } xfer_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    proc_bus_mux_if #(.WIDTH(WIDTH), .NREG(NREG), .ERRW(ERRW)) bif ();

    proc_bus_mux #(.WIDTH(WIDTH), .NREG(NREG), .ERRW(ERRW)) u_dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bif.slave)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    xfer_t sb_q[$];

    logic           m_known = 1'b0;
    logic           m_valid = 1'b0;
    logic           m_err   = 1'b0;
    logic [ERRW-1:0] m_cnt  = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: compare at the falling edge, advance the model, return #1 after the rising edge.
    task automatic step();
        logic  accept, legal;
        int    ones;
        xfer_t e;
        @(negedge clk);
        if (m_known) begin
            chk("sel_ready", {31'd0, bif.sel_ready}, {31'd0, (!m_valid || bif.bus_ready)});
            chk("bus_valid", {31'd0, bif.bus_valid}, {31'd0, m_valid});
            chk("sel_err", {31'd0, bif.sel_err}, {31'd0, m_err});
            chk("err_count", {28'd0, bif.err_count}, {28'd0, m_cnt});
            if (m_valid) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb_q[0];
                    chk("muxout", {16'd0, bif.MUXOut}, {16'd0, e.data});
                    chk("src_code", {30'd0, bif.src_code}, {30'd0, e.src});
                    chk("reg_idx", {29'd0, bif.reg_idx}, {29'd0, e.idx});
                    if (bif.bus_ready) void'(sb_q.pop_front());
                end
            end
        end

        ones = $countones(bif.selectR);
        legal  = bif.selectG || bif.selectDin || (ones == 1);
        accept = bif.sel_valid && (!m_valid || bif.bus_ready);
        if (rst) begin
            sb_q.delete();
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_cnt   = '0;
            m_known = 1'b1;
        end else begin
            if (m_valid && bif.bus_ready) m_valid = 1'b0;
            if (accept && legal) begin
                e = '0;
                if (bif.selectG) begin
                    e.data = bif.G;   e.src = 2'd2;
                end else if (bif.selectDin) begin
                    e.data = bif.DIN; e.src = 2'd1;
                end else begin
                    e.src = 2'd0;
                    for (int k = 0; k < NREG; k++)
                        if (bif.selectR[k]) begin
                            e.idx  = 3'(k);
                            e.data = bif.R_bus[k*WIDTH +: WIDTH];
                        end
                end
                sb_q.push_back(e);
                m_valid = 1'b1;
            end
            if (accept && !legal) begin
                m_err = 1'b1;
                m_cnt = bif.err_clear ? 4'd1 : ((m_cnt == 4'hF) ? m_cnt : m_cnt + 4'd1);
            end else if (bif.err_clear) begin
                m_err = 1'b0;
                m_cnt = '0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_sel();
        bif.sel_valid = 1'b0;
        bif.selectG   = 1'b0;
        bif.selectDin = 1'b0;
        bif.selectR   = '0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_muxout", {16'd0, bif.MUXOut}, 32'd0);
        chk("rst_bus_valid", {31'd0, bif.bus_valid}, 32'd0);
        chk("rst_src_code", {30'd0, bif.src_code}, 32'd3);
        chk("rst_reg_idx", {29'd0, bif.reg_idx}, 32'd0);
        chk("rst_sel_err", {31'd0, bif.sel_err}, 32'd0);
        chk("rst_err_count", {28'd0, bif.err_count}, 32'd0);
        chk("rst_sel_ready", {31'd0, bif.sel_ready}, 32'd1);
    endtask

    logic [WIDTH-1:0] r5_val;
    logic [WIDTH-1:0] held;

    initial begin
        bif.R_bus     = '0;
        bif.DIN       = '0;
        bif.G         = '0;
        bif.bus_ready = 1'b1;
        bif.err_clear = 1'b0;
        idle_sel();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_reset_vals();

        // Register source R3
        for (int k = 0; k < NREG; k++) bif.R_bus[k*WIDTH +: WIDTH] = 16'($urandom);
        bif.R_bus[3*WIDTH +: WIDTH] = 16'h1234;
        bif.sel_valid = 1'b1;
        bif.selectR   = 8'b0000_1000;
        step();
        chk("r3_muxout", {16'd0, bif.MUXOut}, 32'h1234);
        chk("r3_bus_valid", {31'd0, bif.bus_valid}, 32'd1);
        chk("r3_src", {30'd0, bif.src_code}, 32'd0);
        chk("r3_idx", {29'd0, bif.reg_idx}, 32'd3);

        // G wins over DIN and R
        bif.selectG   = 1'b1;
        bif.selectDin = 1'b1;
        bif.selectR   = 8'b0000_0001;
        bif.G         = 16'hBEEF;
        bif.DIN       = 16'h5555;
        step();
        chk("g_muxout", {16'd0, bif.MUXOut}, 32'hBEEF);
        chk("g_src", {30'd0, bif.src_code}, 32'd2);
        idle_sel();
        step();

        // DIN load into a stalled consumer, R5 held off until ready
        bif.bus_ready = 1'b0;
        bif.sel_valid = 1'b1;
        bif.selectDin = 1'b1;
        bif.DIN       = 16'h00AA;
        step();
        bif.selectDin = 1'b0;
        bif.selectR   = 8'b0010_0000;
        r5_val        = 16'h5A5A;
        bif.R_bus[5*WIDTH +: WIDTH] = r5_val;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stall_sel_ready", {31'd0, bif.sel_ready}, 32'd0);
            chk("stall_muxout", {16'd0, bif.MUXOut}, 32'h00AA);
        end
        bif.bus_ready = 1'b1;
        step();
        chk("r5_muxout", {16'd0, bif.MUXOut}, {16'd0, r5_val});
        chk("r5_bus_valid", {31'd0, bif.bus_valid}, 32'd1);
        chk("r5_idx", {29'd0, bif.reg_idx}, 32'd5);

        // Illegal selects: zero-hot then multi-hot, then saturate
        held = bif.MUXOut;
        bif.selectR = 8'b0000_0000;
        step();
        bif.selectR = 8'b0000_0110;
        step();
        chk("ill_sel_err", {31'd0, bif.sel_err}, 32'd1);
        chk("ill_err_count", {28'd0, bif.err_count}, 32'd2);
        chk("ill_bus_valid", {31'd0, bif.bus_valid}, 32'd0);
        chk("ill_muxout_hold", {16'd0, bif.MUXOut}, {16'd0, held});
        for (int c = 0; c < 20; c++) step();
        chk("sat_err_count", {28'd0, bif.err_count}, 32'd15);

        // Clear colliding with an illegal accept
        bif.err_clear = 1'b1;
        step();
        bif.err_clear = 1'b0;
        chk("clr_sel_err", {31'd0, bif.sel_err}, 32'd1);
        chk("clr_err_count", {28'd0, bif.err_count}, 32'd1);
        bif.err_clear = 1'b1;
        idle_sel();
        step();
        bif.err_clear = 1'b0;
        chk("clr_only_count", {28'd0, bif.err_count}, 32'd0);

        // Reset in the middle of a stall
        bif.bus_ready = 1'b0;
        bif.sel_valid = 1'b1;
        bif.selectDin = 1'b1;
        bif.DIN       = 16'hC0DE;
        step();
        bif.selectDin = 1'b0;
        bif.selectG   = 1'b1;
        bif.G         = 16'h1111;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_sel();
        chk_reset_vals();

        // Random traffic with source churn after every accept
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < NREG; k++) bif.R_bus[k*WIDTH +: WIDTH] = 16'($urandom);
            bif.DIN       = 16'($urandom);
            bif.G         = 16'($urandom);
            bif.sel_valid = ($urandom_range(0, 3) != 0);
            bif.bus_ready = ($urandom_range(0, 2) != 0);
            bif.err_clear = ($urandom_range(0, 15) == 0);
            bif.selectG   = ($urandom_range(0, 5) == 0);
            bif.selectDin = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 7) == 0) bif.selectR = 8'($urandom);
            else                           bif.selectR = 8'(1) << $urandom_range(0, NREG-1);
            step();
        end

        idle_sel();
        bif.err_clear = 1'b0;
        bif.bus_ready = 1'b1;
        step();
        step();
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/proc_bus_mux.md
PROC_BUS_MUX -- requirements
Module: proc_bus_mux

Interface
REQ-001 Parameters SHALL be: WIDTH, default 16, bus data width; NREG, default 8, number of register sources (2..16); ERRW, default 4, error-counter width.
REQ-002 Ports SHALL be:
  - Clock, input, 1, sole clock; all state updates on rising edge.
  - Reset, input, 1, synchronous, active-high.
  - R_bus, input, NREG*WIDTH, register sources; Rk occupies bits [k*WIDTH +: WIDTH].
  - DIN, input, WIDTH, external data source.
  - G, input, WIDTH, ALU result source.
  - selectR, input, NREG, one-hot register select; bit k selects Rk.
  - selectG, input, 1, select G.
  - selectDin, input, 1, select DIN.
  - sel_valid, input, 1, select lines meaningful this cycle.
  - sel_ready, output, 1, combinational; block can accept a select this cycle.
  - bus_ready, input, 1, consumer accepts MUXOut this cycle.
  - MUXOut, output, WIDTH, registered bus data.
  - bus_valid, output, 1, MUXOut holds an unconsumed transfer.
  - src_code, output, 2, registered source tag: 0 = register, 1 = DIN, 2 = G, 3 = none.
  - reg_idx, output, clog2(NREG), registered index of the register driven when src_code = 0, else 0.
  - err_clear, input, 1, clears error state.
  - sel_err, output, 1, sticky illegal-select flag.
  - err_count, output, ERRW, saturating illegal-select count.
REQ-003 Clock and reset SHALL be exactly as fixed: one clock, Clock; Reset synchronous and active-high.

Function
REQ-004 sel_ready SHALL equal (!bus_valid || bus_ready).
REQ-005 Source priority SHALL be selectG > selectDin > selectR; lower-priority lines are ignored when a higher one is set.
REQ-006 With selectG = selectDin = 0, a select SHALL be legal only if selectR has exactly one bit set; zero-hot or multi-hot is illegal.
REQ-007 Accept condition SHALL be sel_valid && sel_ready.
REQ-008 On legal accept: next edge MUXOut <= selected data, bus_valid <= 1, src_code and reg_idx updated; latency exactly 1 cycle.
REQ-009 Data SHALL be sampled in the accept cycle; later source changes do not affect MUXOut.
REQ-010 On illegal accept: no transfer; MUXOut, src_code, reg_idx unchanged; bus_valid <= 0 if bus_ready was 1, else unchanged.
REQ-011 When bus_valid && bus_ready and no legal accept: bus_valid <= 0; MUXOut, src_code, reg_idx hold last value.
REQ-012 Back-to-back: bus_valid && bus_ready with legal accept in the same cycle SHALL load the new transfer; bus_valid stays 1; no bubble.
REQ-013 Stall: bus_valid && !bus_ready SHALL hold MUXOut, src_code, reg_idx, bus_valid; sel_ready = 0; selects are not sampled or error-checked.
REQ-014 sel_valid = 0 SHALL cause no transfer and no error check.
REQ-015 Illegal accept SHALL set sel_err and increment err_count, saturating at 2^ERRW-1.
REQ-016 err_clear SHALL zero sel_err and err_count next edge; with an illegal accept in the same cycle, result is sel_err = 1, err_count = 1.
REQ-017 The block SHALL hold no combinational path from data inputs to MUXOut.

Reset
REQ-018 Reset high at an edge SHALL force MUXOut = 0, bus_valid = 0, src_code = 3, reg_idx = 0, sel_err = 0, err_count = 0, overriding all other inputs.
REQ-019 Reset mid-stall SHALL discard the pending transfer; sel_ready = 1 in the first cycle after reset.

Verification
REQ-020 Bench SHALL cover the following directed scenarios (defaults):
  - Reset, then sel_valid = 1, selectR = 8'b00001000, R3 = 16'h1234, bus_ready = 1 -> next cycle MUXOut = 16'h1234, bus_valid = 1, src_code = 0, reg_idx = 3.
  - selectG = selectDin = 1, selectR = 8'b00000001, G = 16'hBEEF -> MUXOut = 16'hBEEF, src_code = 2.
  - Load DIN = 16'h00AA with bus_ready = 0, then present selectR = R5 for 3 cycles -> sel_ready = 0, MUXOut holds 16'h00AA; bus_ready = 1 -> R5 loads next edge, bus_valid stays 1.
  - selectR = 8'b00000000, then 8'b00000110, each accepted -> no transfer, sel_err = 1, err_count = 2; 20 more illegal accepts -> err_count = 15.
  - err_clear with simultaneous illegal accept -> sel_err = 1, err_count = 1.
  - Reset asserted during stall with bus_valid = 1 -> all outputs at REQ-018 values next cycle; sel_ready = 1.
